// File: rtl/i2c_codec_config.sv
// Boot-time codec register loader: walks a table of {reg_addr, reg_data} words and issues one
// I2C write per entry through i2c_master, retrying NACKed writes and reporting done or fail.
module i2c_codec_config #(
    parameter int unsigned NUM_REGS   = 11,
    parameter int unsigned IDX_W      = 4,
    parameter logic [6:0]  DEV_ADDR   = 7'h1A,
    parameter int unsigned MAX_RETRY  = 3,
    parameter int unsigned GAP_CYCLES = 16,
    parameter bit          AUTO_START = 1'b1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    output logic [IDX_W-1:0] tbl_index,
    input  logic [15:0]      tbl_word,
    output logic             m_start_transaction,
    output logic             m_end_transaction,
    output logic             m_start_write,
    output logic             m_start_read,
    output logic [7:0]       m_data_out,
    input  logic             m_ready,
    input  logic             m_error,
    output logic             busy,
    output logic             done,
    output logic             fail,
    output logic [IDX_W-1:0] fail_index,
    output logic [3:0]       state_dbg,
    output logic [1:0]       phase_dbg
);

    typedef enum logic [3:0] {
        S_IDLE, S_GAP, S_START, S_WR_DEV, S_WR_HI, S_WR_LO, S_STOP, S_NEXT, S_DONE, S_FAIL
    } state_t;

    typedef enum logic [1:0] {PH_ISSUE, PH_HOLD, PH_WAIT} phase_t;

    localparam int unsigned    GAP_W    = $clog2(GAP_CYCLES);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);
    localparam logic [3:0]     MAX_R    = 4'(MAX_RETRY);

    state_t           state;
    phase_t           phase;
    logic [GAP_W-1:0] gap_cnt;
    logic [3:0]       retry;
    logic             retry_pend;
    logic             auto_go;
    logic             is_write;
    logic [7:0]       cmd_byte;
    state_t           next_write;

    assign m_start_read = 1'b0;
    assign state_dbg    = state;
    assign phase_dbg    = phase;

    always_comb begin
        is_write   = 1'b0;
        cmd_byte   = 8'h00;
        next_write = S_STOP;
        case (state)
            S_WR_DEV: begin is_write = 1'b1; cmd_byte = {DEV_ADDR, 1'b0}; next_write = S_WR_HI; end
            S_WR_HI:  begin is_write = 1'b1; cmd_byte = tbl_word[15:8];   next_write = S_WR_LO; end
            S_WR_LO:  begin is_write = 1'b1; cmd_byte = tbl_word[7:0];    next_write = S_STOP;  end
            default:  ;
        endcase
    end

    // Command handshake with i2c_master: a command pulse is launched only while m_ready=1,
    // lasts exactly one clock, the following clock is skipped (ready is still stale), and the
    // command is complete on the first later clock with m_ready=1, when m_error is valid.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state               <= S_IDLE;
            phase               <= PH_ISSUE;
            gap_cnt             <= '0;
            retry               <= '0;
            retry_pend          <= 1'b0;
            auto_go             <= AUTO_START;
            tbl_index           <= '0;
            m_start_transaction <= 1'b0;
            m_end_transaction   <= 1'b0;
            m_start_write       <= 1'b0;
            m_data_out          <= 8'h00;
            busy                <= 1'b0;
            done                <= 1'b0;
            fail                <= 1'b0;
            fail_index          <= '0;
        end else begin
            m_start_transaction <= 1'b0;
            m_end_transaction   <= 1'b0;
            m_start_write       <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start || auto_go) begin
                        auto_go    <= 1'b0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        fail       <= 1'b0;
                        tbl_index  <= '0;
                        retry      <= '0;
                        retry_pend <= 1'b0;
                        gap_cnt    <= '0;
                        state      <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        gap_cnt <= '0;
                        phase   <= PH_ISSUE;
                        state   <= S_START;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                S_NEXT: begin
                    retry <= '0;
                    if (tbl_index == LAST_IDX) begin
                        state <= S_DONE;
                    end else begin
                        tbl_index <= tbl_index + IDX_W'(1);
                        gap_cnt   <= '0;
                        state     <= S_GAP;
                    end
                end
                S_DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                S_FAIL: begin
                    fail  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    case (phase)
                        PH_ISSUE: begin
                            if (m_ready) begin
                                m_start_transaction <= (state == S_START);
                                m_end_transaction   <= (state == S_STOP);
                                m_start_write       <= is_write;
                                if (is_write) m_data_out <= cmd_byte;
                                phase <= PH_HOLD;
                            end
                        end
                        PH_HOLD: phase <= PH_WAIT;
                        default: begin
                            if (m_ready) begin
                                phase <= PH_ISSUE;
                                if (state == S_START) begin
                                    state <= S_WR_DEV;
                                end else if (is_write) begin
                                    // A NACK abandons the remaining bytes; STOP then decides on a retry.
                                    if (m_error) begin
                                        retry_pend <= 1'b1;
                                        state      <= S_STOP;
                                    end else begin
                                        state <= next_write;
                                    end
                                end else if (!retry_pend) begin
                                    state <= S_NEXT;
                                end else if (retry < MAX_R) begin
                                    retry      <= retry + 4'd1;
                                    retry_pend <= 1'b0;
                                    gap_cnt    <= '0;
                                    state      <= S_GAP;
                                end else begin
                                    retry_pend <= 1'b0;
                                    fail_index <= tbl_index;
                                    state      <= S_FAIL;
                                end
                            end
                        end
                    endcase
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_codec_config.sv
// Bench for i2c_codec_config: command-level i2c_master/slave model logging bus events,
// compared against an entry/attempt-level model of the expected bus traffic.
module tb_i2c_codec_config;
  localparam int NREGS = 4;
  localparam int IDX_W = 4;
  localparam int MAXR  = 3;
  localparam int GAP   = 4;
  localparam logic [9:0] EV_S = 10'h200;
  localparam logic [9:0] EV_P = 10'h300;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             start = 1'b0;
  logic [IDX_W-1:0] tbl_index;
  logic [15:0]      tbl_word = 16'h0000;
  logic             m_start_transaction, m_end_transaction, m_start_write, m_start_read;
  logic [7:0]       m_data_out;
  logic             m_ready, m_error;
  logic             busy, done, fail;
  logic [IDX_W-1:0] fail_index;
  logic [3:0]       state_dbg;
  logic [1:0]       phase_dbg;

  int checks = 0;
  int errors = 0;

  logic [15:0] rom [0:15];
  logic [9:0]  log_q[$];
  logic [9:0]  exp_q[$];
  int          nack_at [0:63];
  int          start_cnt = 0;
  int          attempt_base = 0;
  int          base = 0;

  bit rdy = 1'b1, err = 1'b0, stall = 1'b0, cur_write = 1'b0;
  int cur_pos = 0, byte_pos = 0, cnt = 0, cur_att = 0;

  i2c_codec_config #(
    .NUM_REGS(NREGS), .IDX_W(IDX_W), .DEV_ADDR(7'h1A), .MAX_RETRY(MAXR),
    .GAP_CYCLES(GAP), .AUTO_START(1'b1)
  ) dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .tbl_index(tbl_index), .tbl_word(tbl_word),
    .m_start_transaction(m_start_transaction), .m_end_transaction(m_end_transaction),
    .m_start_write(m_start_write), .m_start_read(m_start_read), .m_data_out(m_data_out),
    .m_ready(m_ready), .m_error(m_error),
    .busy(busy), .done(done), .fail(fail), .fail_index(fail_index),
    .state_dbg(state_dbg), .phase_dbg(phase_dbg)
  );

  // clock / reset
  always #5 clock = ~clock;

  // synchronous table ROM
  always @(posedge clock) tbl_word <= rom[tbl_index];

  assign m_ready = rdy & ~stall;
  assign m_error = err;

  // master + slave model: log each command, drop ready, finish after a random delay
  always @(negedge clock) begin
    int npulse;
    npulse = int'(m_start_transaction) + int'(m_end_transaction) + int'(m_start_write) + int'(m_start_read);
    if (npulse != 0) begin
      checks++;
      if (npulse != 1 || m_start_read !== 1'b0) begin
        errors++;
        $display("FAIL one_hot: got %0d pulses (read=%b), required 1 (read=0) at %0t", npulse, m_start_read, $time);
      end
      if (m_start_transaction) begin
        log_q.push_back(EV_S);
        start_cnt++;
        byte_pos  = 0;
        cur_write = 1'b0;
      end else if (m_start_write) begin
        log_q.push_back({2'b00, m_data_out});
        cur_write = 1'b1;
        cur_pos   = byte_pos;
        byte_pos++;
        cur_att   = start_cnt - 1 - attempt_base;
      end else begin
        log_q.push_back(EV_P);
        cur_write = 1'b0;
      end
      rdy = 1'b0;
      cnt = $urandom_range(1, 4);
    end else if (!rdy) begin
      cnt--;
      if (cnt == 0) begin
        rdy = 1'b1;
        err = cur_write && cur_att >= 0 && cur_att < 64 && nack_at[cur_att] == cur_pos;
      end
    end
  end

  // reference model: expected bus events per entry and attempt
  function automatic logic [7:0] byte_of(int e, int b);
    logic [15:0] w;
    w = rom[e];
    if (b == 0) return 8'h34;
    if (b == 1) return w[15:8];
    return w[7:0];
  endfunction

  task automatic build_expected(output bit exp_done, output int exp_fidx);
    int a, nacks, np;
    bit acked;
    a = 0;
    exp_q.delete();
    exp_done = 1'b0;
    exp_fidx = 0;
    for (int e = 0; e < NREGS; e++) begin
      nacks = 0;
      acked = 1'b0;
      while (!acked) begin
        np = (a < 64) ? nack_at[a] : 3;
        a++;
        exp_q.push_back(EV_S);
        for (int b = 0; b < 3; b++) begin
          exp_q.push_back({2'b00, byte_of(e, b)});
          if (np == b) break;
        end
        exp_q.push_back(EV_P);
        if (np >= 3) acked = 1'b1;
        else if (nacks == MAXR) begin
          exp_fidx = e;
          return;
        end else nacks++;
      end
    end
    exp_done = 1'b1;
  endtask

  function automatic int first_diff();
    int n;
    n = log_q.size() - base;
    for (int i = 0; i < n || i < exp_q.size(); i++) begin
      if (i >= n || i >= exp_q.size()) return i;
      if (log_q[base + i] !== exp_q[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [9:0] ev_got(int i);
    if (i < 0 || base + i >= log_q.size()) return 10'h3FF;
    return log_q[base + i];
  endfunction

  function automatic logic [9:0] ev_exp(int i);
    if (i < 0 || i >= exp_q.size()) return 10'h3FF;
    return exp_q[i];
  endfunction

  // driver tasks
  task automatic clear_nacks();
    for (int i = 0; i < 64; i++) nack_at[i] = 3;
  endtask

  task automatic snapshot();
    base = log_q.size();
    attempt_base = start_cnt;
  endtask

  task automatic pulse_start();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_idle(output bit timed_out);
    bit seen;
    seen = 1'b0;
    timed_out = 1'b1;
    for (int n = 0; n < 20000; n++) begin
      @(negedge clock);
      if (busy) seen = 1'b1;
      else if (seen) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  // tests
  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if ({busy, done, fail} !== 3'b000) begin
      errors++; $display("FAIL reset_status: got busy/done/fail=%b required 000", {busy, done, fail});
    end
    checks++;
    if ({m_start_transaction, m_end_transaction, m_start_write, m_start_read} !== 4'b0000) begin
      errors++; $display("FAIL reset_pulses: got %b required 0000",
        {m_start_transaction, m_end_transaction, m_start_write, m_start_read});
    end
    checks++;
    if ({tbl_index, fail_index, m_data_out} !== 16'h0000) begin
      errors++; $display("FAIL reset_regs: got idx=%h fidx=%h data=%h required 0", tbl_index, fail_index, m_data_out);
    end
  endtask

  task automatic test_auto_start();
    bit to, ed;
    int ef, d;
    clear_nacks();
    rom[0] = 16'h1E00; rom[1] = 16'h0C00; rom[2] = 16'h0A17; rom[3] = 16'h12C3;
    snapshot();
    @(negedge clock);
    reset_n = 1'b1;
    wait_idle(to);
    build_expected(ed, ef);
    d = first_diff();
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL auto_timeout: got timeout=1 required 0"); end
    checks++; if (d !== -1) begin errors++; $display("FAIL auto_bus: event %0d got %h required %h", d, ev_got(d), ev_exp(d)); end
    checks++; if ({done, fail, busy} !== {ed, 1'b0, 1'b0}) begin errors++; $display("FAIL auto_status: got done/fail/busy=%b required %b00", {done, fail, busy}, ed); end
  endtask

  task automatic test_nack_dev();
    bit to, ed;
    int ef, d;
    clear_nacks();
    nack_at[1] = 0; nack_at[2] = 0;
    snapshot();
    pulse_start();
    wait_idle(to);
    build_expected(ed, ef);
    d = first_diff();
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL nackdev_timeout: got timeout=1 required 0"); end
    checks++; if (d !== -1) begin errors++; $display("FAIL nackdev_bus: event %0d got %h required %h", d, ev_got(d), ev_exp(d)); end
    checks++; if ({done, fail, busy} !== 3'b100) begin errors++; $display("FAIL nackdev_status: got done/fail/busy=%b required 100", {done, fail, busy}); end
  endtask

  task automatic test_nack_lo();
    bit to, ed;
    int ef, d;
    clear_nacks();
    nack_at[0] = 2; nack_at[3] = 1;
    snapshot();
    pulse_start();
    wait_idle(to);
    build_expected(ed, ef);
    d = first_diff();
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL nacklo_timeout: got timeout=1 required 0"); end
    checks++; if (d !== -1) begin errors++; $display("FAIL nacklo_bus: event %0d got %h required %h", d, ev_got(d), ev_exp(d)); end
    checks++; if ({done, fail, busy} !== 3'b100) begin errors++; $display("FAIL nacklo_status: got done/fail/busy=%b required 100", {done, fail, busy}); end
  endtask

  task automatic test_fail();
    bit to, ed;
    int ef, d;
    clear_nacks();
    nack_at[2] = 0; nack_at[3] = 1; nack_at[4] = 2; nack_at[5] = 0;
    snapshot();
    pulse_start();
    wait_idle(to);
    build_expected(ed, ef);
    d = first_diff();
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL fail_timeout: got timeout=1 required 0"); end
    checks++; if (d !== -1) begin errors++; $display("FAIL fail_bus: event %0d got %h required %h", d, ev_got(d), ev_exp(d)); end
    checks++; if ({done, fail, busy} !== 3'b010) begin errors++; $display("FAIL fail_status: got done/fail/busy=%b required 010", {done, fail, busy}); end
    checks++; if (fail_index !== IDX_W'(2)) begin errors++; $display("FAIL fail_index: got %0d required 2", fail_index); end
    checks++; if (start_cnt - attempt_base !== 6) begin errors++; $display("FAIL fail_attempts: got %0d required 6", start_cnt - attempt_base); end
  endtask

  task automatic test_ready_hold();
    bit to, ed;
    int ef, d;
    clear_nacks();
    stall = 1'b1;
    snapshot();
    pulse_start();
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (i == 50) start = 1'b1;
      if (i == 51) start = 1'b0;
      checks++;
      if ({m_start_transaction, m_end_transaction, m_start_write, busy} !== 4'b0001) begin
        errors++; $display("FAIL hold_no_cmd: cycle %0d got pulses+busy=%b required 0001", i,
          {m_start_transaction, m_end_transaction, m_start_write, busy});
      end
    end
    stall = 1'b0;
    wait_idle(to);
    build_expected(ed, ef);
    d = first_diff();
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL hold_timeout: got timeout=1 required 0"); end
    checks++; if (d !== -1) begin errors++; $display("FAIL hold_bus: event %0d got %h required %h", d, ev_got(d), ev_exp(d)); end
    checks++; if ({done, fail, busy} !== 3'b100) begin errors++; $display("FAIL hold_status: got done/fail/busy=%b required 100", {done, fail, busy}); end
  endtask

  task automatic test_reset_mid();
    bit to, ed, hit;
    int ef, d;
    clear_nacks();
    snapshot();
    pulse_start();
    hit = 1'b0;
    for (int n = 0; n < 2000 && !hit; n++) begin
      @(negedge clock);
      if (log_q.size() - base >= 3) hit = 1'b1;
    end
    checks++; if (hit !== 1'b1) begin errors++; $display("FAIL mid_reach_hi: got hit=0 required 1"); end
    reset_n = 1'b0;
    snapshot();
    @(negedge clock);
    checks++;
    if ({busy, done, fail, m_start_transaction, m_end_transaction, m_start_write, tbl_index, m_data_out} !== 18'h0) begin
      errors++; $display("FAIL mid_reset_vals: got busy=%b done=%b fail=%b idx=%h data=%h required 0",
        busy, done, fail, tbl_index, m_data_out);
    end
    reset_n = 1'b1;
    wait_idle(to);
    build_expected(ed, ef);
    d = first_diff();
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL mid_timeout: got timeout=1 required 0"); end
    checks++; if (d !== -1) begin errors++; $display("FAIL mid_bus: event %0d got %h required %h", d, ev_got(d), ev_exp(d)); end
    checks++; if ({done, fail, busy} !== 3'b100) begin errors++; $display("FAIL mid_status: got done/fail/busy=%b required 100", {done, fail, busy}); end
  endtask

  task automatic test_random();
    bit to, ed;
    int ef, d;
    for (int it = 0; it < 8; it++) begin
      for (int e = 0; e < NREGS; e++) rom[e] = 16'($urandom);
      for (int a = 0; a < 64; a++)
        nack_at[a] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 2)) : 3;
      snapshot();
      pulse_start();
      wait_idle(to);
      build_expected(ed, ef);
      d = first_diff();
      checks++; if (to !== 1'b0) begin errors++; $display("FAIL rand%0d_timeout: got timeout=1 required 0", it); end
      checks++; if (d !== -1) begin errors++; $display("FAIL rand%0d_bus: event %0d got %h required %h", it, d, ev_got(d), ev_exp(d)); end
      checks++; if ({done, fail} !== {ed, ~ed}) begin errors++; $display("FAIL rand%0d_status: got done/fail=%b required %b", it, {done, fail}, {ed, ~ed}); end
      if (!ed) begin
        checks++; if (fail_index !== IDX_W'(ef)) begin errors++; $display("FAIL rand%0d_fidx: got %0d required %0d", it, fail_index, ef); end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 16'h0000;
    clear_nacks();
    test_reset();
    test_auto_start();
    test_nack_dev();
    test_nack_lo();
    test_fail();
    test_ready_hold();
    test_reset_mid();
    test_random();
    repeat (5) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
